// File: rtl/rob.sv
// Reorder buffer: allocates entries in program order, resolves source operands
// against its own entries and the CDB, reserves rd, and retires in order.
`timescale 1ns/1ps
module rob #(
  parameter int ROB_SIZE = 16,
  parameter int ROB_W    = 4,
  parameter int REG_W    = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              dispatch_valid,
  output logic              dispatch_ready,
  input  logic              dispatch_has_rd,
  input  logic [REG_W-1:0]  dispatch_rd,
  input  logic [REG_W-1:0]  dispatch_rs1,
  input  logic [REG_W-1:0]  dispatch_rs2,
  output logic [ROB_W-1:0]  dispatch_tag,
  output logic              op1_ready,
  output logic              op2_ready,
  output logic [DATA_W-1:0] op1_value,
  output logic [DATA_W-1:0] op2_value,
  output logic [ROB_W-1:0]  op1_tag,
  output logic [ROB_W-1:0]  op2_tag,
  output logic [REG_W-1:0]  rob2reg_rs1_request,
  output logic [REG_W-1:0]  rob2reg_rs2_request,
  input  logic [DATA_W-1:0] reg2rob_rs1_value,
  input  logic [DATA_W-1:0] reg2rob_rs2_value,
  input  logic [ROB_W-1:0]  reg2rob_rs1_rename,
  input  logic [ROB_W-1:0]  reg2rob_rs2_rename,
  input  logic              reg2rob_rs1_if_rename,
  input  logic              reg2rob_rs2_if_rename,
  output logic              rob2reg_reserve_enable,
  output logic [REG_W-1:0]  rob2reg_reserve_rd,
  output logic [ROB_W-1:0]  rob2reg_reserve_reorder,
  input  logic              wb_valid,
  input  logic [ROB_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_value,
  output logic              rob2reg_commit_enable,
  output logic [REG_W-1:0]  rob2reg_commit_des,
  output logic [DATA_W-1:0] rob2reg_commit_value,
  output logic [ROB_W-1:0]  rob2reg_commit_reorder,
  output logic              rob_full,
  output logic              rob_empty
);

  typedef struct packed {
    logic              ready;
    logic [DATA_W-1:0] value;
    logic [ROB_W-1:0]  tag;
  } opnd_t;

  localparam logic [ROB_W:0]   LP_FULL    = (ROB_W+1)'(ROB_SIZE);
  localparam logic [ROB_W:0]   LP_CNT_ONE = (ROB_W+1)'(1);
  localparam logic [ROB_W-1:0] LP_TAG_ONE = ROB_W'(1);

  logic [ROB_SIZE-1:0] r_valid;
  logic [ROB_SIZE-1:0] r_ready;
  logic [ROB_SIZE-1:0] r_has_rd;
  logic [REG_W-1:0]    r_rd    [ROB_SIZE];
  logic [DATA_W-1:0]   r_value [ROB_SIZE];
  logic [ROB_W-1:0]    r_head;
  logic [ROB_W-1:0]    r_tail;
  logic [ROB_W:0]      r_count;

  logic  w_full;
  logic  w_empty;
  logic  w_accept;
  logic  w_retire;
  logic  w_wb_hit;
  logic  w_reserve;
  logic  w_commit;
  opnd_t w_op1;
  opnd_t w_op2;

  // Priority: x0, unrenamed register, completed producer, same-cycle CDB bypass.
  function automatic opnd_t resolve(
    input logic [REG_W-1:0]  rs,
    input logic              renamed,
    input logic [ROB_W-1:0]  rn,
    input logic [DATA_W-1:0] rf_value,
    input logic              ent_ready,
    input logic [DATA_W-1:0] ent_value,
    input logic              bypass,
    input logic [DATA_W-1:0] bp_value
  );
    opnd_t o;
    o = '0;
    if (rs == '0) begin
      o.ready = 1'b1;
    end else if (!renamed) begin
      o.ready = 1'b1;
      o.value = rf_value;
    end else if (ent_ready) begin
      o.ready = 1'b1;
      o.value = ent_value;
    end else if (bypass) begin
      o.ready = 1'b1;
      o.value = bp_value;
    end else begin
      o.tag = rn;
    end
    return o;
  endfunction

  assign w_full         = (r_count == LP_FULL);
  assign w_empty        = (r_count == '0);
  assign dispatch_ready = !w_full && rdy_in && !flush_in;
  assign w_accept       = dispatch_valid && dispatch_ready;
  assign w_retire       = rdy_in && !flush_in && !w_empty && r_ready[r_head];
  assign w_wb_hit       = wb_valid && r_valid[wb_tag];
  assign w_reserve      = w_accept && dispatch_has_rd && (dispatch_rd != '0);
  assign w_commit       = w_retire && r_has_rd[r_head] && (r_rd[r_head] != '0);

  assign w_op1 = resolve(dispatch_rs1, reg2rob_rs1_if_rename, reg2rob_rs1_rename,
                         reg2rob_rs1_value, r_ready[reg2rob_rs1_rename],
                         r_value[reg2rob_rs1_rename],
                         wb_valid && (wb_tag == reg2rob_rs1_rename), wb_value);
  assign w_op2 = resolve(dispatch_rs2, reg2rob_rs2_if_rename, reg2rob_rs2_rename,
                         reg2rob_rs2_value, r_ready[reg2rob_rs2_rename],
                         r_value[reg2rob_rs2_rename],
                         wb_valid && (wb_tag == reg2rob_rs2_rename), wb_value);

  assign op1_ready           = w_op1.ready;
  assign op1_value           = w_op1.value;
  assign op1_tag             = w_op1.tag;
  assign op2_ready           = w_op2.ready;
  assign op2_value           = w_op2.value;
  assign op2_tag             = w_op2.tag;
  assign dispatch_tag        = r_tail;
  assign rob2reg_rs1_request = dispatch_rs1;
  assign rob2reg_rs2_request = dispatch_rs2;
  assign rob_full            = w_full;
  assign rob_empty           = w_empty;

  // Rename-table reservation and commit port, zeroed when idle.
  always_comb begin
    rob2reg_reserve_enable  = 1'b0;
    rob2reg_reserve_rd      = '0;
    rob2reg_reserve_reorder = '0;
    rob2reg_commit_enable   = 1'b0;
    rob2reg_commit_des      = '0;
    rob2reg_commit_value    = '0;
    rob2reg_commit_reorder  = '0;
    if (w_reserve) begin
      rob2reg_reserve_enable  = 1'b1;
      rob2reg_reserve_rd      = dispatch_rd;
      rob2reg_reserve_reorder = r_tail;
    end else begin
      rob2reg_reserve_enable  = 1'b0;
    end
    if (w_commit) begin
      rob2reg_commit_enable  = 1'b1;
      rob2reg_commit_des     = r_rd[r_head];
      rob2reg_commit_value   = r_value[r_head];
      rob2reg_commit_reorder = r_head;
    end else begin
      rob2reg_commit_enable  = 1'b0;
    end
  end

  // Entry state and pointers; retire keeps ready/value so stale tags stay readable.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_valid  <= '0;
      r_ready  <= '0;
      r_has_rd <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        r_rd[i]    <= '0;
        r_value[i] <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_valid <= '0;
      end else begin
        if (w_wb_hit) begin
          r_ready[wb_tag] <= 1'b1;
          r_value[wb_tag] <= wb_value;
        end
        if (w_retire) begin
          r_valid[r_head] <= 1'b0;
          r_head          <= r_head + LP_TAG_ONE;
        end
        if (w_accept) begin
          r_valid[r_tail]  <= 1'b1;
          r_ready[r_tail]  <= 1'b0;
          r_has_rd[r_tail] <= dispatch_has_rd;
          r_rd[r_tail]     <= dispatch_rd;
          r_tail           <= r_tail + LP_TAG_ONE;
        end
        case ({w_accept, w_retire})
          2'b10:   r_count <= r_count + LP_CNT_ONE;
          2'b01:   r_count <= r_count - LP_CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rob.sv
// Bench for rob: program-order queue model plus directed scenarios and random traffic.
`timescale 1ns/1ps
module tb_rob;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in, dispatch_valid, dispatch_has_rd;
  logic [4:0]  dispatch_rd, dispatch_rs1, dispatch_rs2;
  logic        dispatch_ready;
  logic [3:0]  dispatch_tag, op1_tag, op2_tag;
  logic        op1_ready, op2_ready;
  logic [31:0] op1_value, op2_value;
  logic [4:0]  rs1_req, rs2_req;
  logic [31:0] rs1_val, rs2_val;
  logic [3:0]  rs1_rn, rs2_rn;
  logic        rs1_ifr, rs2_ifr;
  logic        res_en;
  logic [4:0]  res_rd;
  logic [3:0]  res_tag;
  logic        wb_valid;
  logic [3:0]  wb_tag;
  logic [31:0] wb_value;
  logic        com_en;
  logic [4:0]  com_des;
  logic [31:0] com_val;
  logic [3:0]  com_tag;
  logic        rob_full, rob_empty;

  always #5 clk_in = ~clk_in;

  rob dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_has_rd(dispatch_has_rd), .dispatch_rd(dispatch_rd),
    .dispatch_rs1(dispatch_rs1), .dispatch_rs2(dispatch_rs2), .dispatch_tag(dispatch_tag),
    .op1_ready(op1_ready), .op2_ready(op2_ready), .op1_value(op1_value), .op2_value(op2_value),
    .op1_tag(op1_tag), .op2_tag(op2_tag),
    .rob2reg_rs1_request(rs1_req), .rob2reg_rs2_request(rs2_req),
    .reg2rob_rs1_value(rs1_val), .reg2rob_rs2_value(rs2_val),
    .reg2rob_rs1_rename(rs1_rn), .reg2rob_rs2_rename(rs2_rn),
    .reg2rob_rs1_if_rename(rs1_ifr), .reg2rob_rs2_if_rename(rs2_ifr),
    .rob2reg_reserve_enable(res_en), .rob2reg_reserve_rd(res_rd),
    .rob2reg_reserve_reorder(res_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .rob2reg_commit_enable(com_en), .rob2reg_commit_des(com_des),
    .rob2reg_commit_value(com_val), .rob2reg_commit_reorder(com_tag),
    .rob_full(rob_full), .rob_empty(rob_empty)
  );

  // Model: in-flight instructions in program order, plus per-tag completion record.
  typedef struct {
    logic [3:0] tag;
    bit         has_rd;
    logic [4:0] rd;
  } ent_t;
  ent_t        q[$];
  bit          done[16];
  logic [31:0] val[16];
  logic [3:0]  m_tail;
  bit          m_acc, m_ret;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic bit in_q(input logic [3:0] t);
    foreach (q[i]) if (q[i].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_tail = 4'd0;
    foreach (done[i]) done[i] = 1'b0;
  endtask

  task automatic exp_op(input logic [4:0] rs, input logic ifr, input logic [3:0] rn,
                        input logic [31:0] rv, output logic r, output logic [31:0] v);
    r = 1'b1;
    v = 32'd0;
    if (rs == 5'd0) r = 1'b1;
    else if (!ifr) v = rv;
    else if (done[rn]) v = val[rn];
    else if (wb_valid && wb_tag == rn) v = wb_value;
    else r = 1'b0;
  endtask

  task automatic idle();
    rdy_in = 1'b1; flush_in = 1'b0; dispatch_valid = 1'b0; dispatch_has_rd = 1'b0;
    dispatch_rd = 5'd0; dispatch_rs1 = 5'd0; dispatch_rs2 = 5'd0;
    rs1_val = 32'd0; rs2_val = 32'd0; rs1_rn = 4'd0; rs2_rn = 4'd0;
    rs1_ifr = 1'b0; rs2_ifr = 1'b0; wb_valid = 1'b0; wb_tag = 4'd0; wb_value = 32'd0;
  endtask

  // Compare every DUT output with what the model says for the current inputs.
  task automatic settle();
    logic        er, exp_dr, exp_res, exp_com;
    logic [31:0] ev;
    #1;
    exp_dr = (q.size() < 16) && rdy_in && !flush_in;
    m_acc  = dispatch_valid && exp_dr;
    m_ret  = 1'b0;
    if (rdy_in && !flush_in && q.size() > 0) m_ret = done[q[0].tag];
    chk("dispatch_ready", 32'(dispatch_ready), 32'(exp_dr));
    chk("dispatch_tag", 32'(dispatch_tag), 32'(m_tail));
    chk("rob_full", 32'(rob_full), 32'(q.size() == 16));
    chk("rob_empty", 32'(rob_empty), 32'(q.size() == 0));
    chk("rs1_request", 32'(rs1_req), 32'(dispatch_rs1));
    chk("rs2_request", 32'(rs2_req), 32'(dispatch_rs2));
    exp_res = m_acc && dispatch_has_rd && dispatch_rd != 5'd0;
    chk("reserve_en", 32'(res_en), 32'(exp_res));
    if (exp_res) begin
      chk("reserve_rd", 32'(res_rd), 32'(dispatch_rd));
      chk("reserve_tag", 32'(res_tag), 32'(m_tail));
    end
    exp_com = 1'b0;
    if (m_ret) exp_com = q[0].has_rd && q[0].rd != 5'd0;
    chk("commit_en", 32'(com_en), 32'(exp_com));
    if (exp_com) begin
      chk("commit_des", 32'(com_des), 32'(q[0].rd));
      chk("commit_val", com_val, val[q[0].tag]);
      chk("commit_tag", 32'(com_tag), 32'(q[0].tag));
    end
    exp_op(dispatch_rs1, rs1_ifr, rs1_rn, rs1_val, er, ev);
    chk("op1_ready", 32'(op1_ready), 32'(er));
    chk("op1_value", op1_value, ev);
    if (!er) chk("op1_tag", 32'(op1_tag), 32'(rs1_rn));
    exp_op(dispatch_rs2, rs2_ifr, rs2_rn, rs2_val, er, ev);
    chk("op2_ready", 32'(op2_ready), 32'(er));
    chk("op2_value", op2_value, ev);
    if (!er) chk("op2_tag", 32'(op2_tag), 32'(rs2_rn));
  endtask

  task automatic advance();
    ent_t e;
    if (!rst_in) model_reset();
    else if (rdy_in) begin
      if (flush_in) begin
        q.delete();
        m_tail = 4'd0;
      end else begin
        if (wb_valid && in_q(wb_tag)) begin
          done[wb_tag] = 1'b1;
          val[wb_tag]  = wb_value;
        end
        if (m_ret) void'(q.pop_front());
        if (m_acc) begin
          e.tag = m_tail; e.has_rd = dispatch_has_rd; e.rd = dispatch_rd;
          q.push_back(e);
          done[m_tail] = 1'b0;
          m_tail++;
        end
      end
    end
    @(negedge clk_in);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic do_reset();
    idle();
    rst_in = 1'b0;
    model_reset();
    step();
    rst_in = 1'b1;
  endtask

  task automatic disp(input logic [4:0] rd);
    dispatch_valid = 1'b1; dispatch_has_rd = 1'b1; dispatch_rd = rd;
  endtask

  function automatic logic [3:0] pick_tag();
    if (q.size() > 0 && $urandom_range(0, 1) == 1) return q[$urandom_range(0, q.size() - 1)].tag;
    return 4'($urandom);
  endfunction

  initial begin
    logic [3:0] cand[$];
    idle();
    rst_in = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_in);
    settle();
    chk("rst_empty", 32'(rob_empty), 32'd1);
    chk("rst_full", 32'(rob_full), 32'd0);
    chk("rst_commit", 32'(com_en), 32'd0);
    chk("rst_reserve", 32'(res_en), 32'd0);
    chk("rst_dready", 32'(dispatch_ready), 32'd1);
    advance();
    rst_in = 1'b1;

    // Two dispatches from a clean register file.
    disp(5'd1); dispatch_rs1 = 5'd3; dispatch_rs2 = 5'd4; rs1_val = 32'h11; rs2_val = 32'h22;
    settle();
    chk("d0_tag", 32'(dispatch_tag), 32'd0);
    chk("d0_res_en", 32'(res_en), 32'd1);
    chk("d0_res_rd", 32'(res_rd), 32'd1);
    chk("d0_res_tag", 32'(res_tag), 32'd0);
    chk("d0_op1", op1_value, 32'h11);
    chk("d0_op2", op2_value, 32'h22);
    advance();
    disp(5'd2);
    settle();
    chk("d1_tag", 32'(dispatch_tag), 32'd1);
    chk("d1_res_rd", 32'(res_rd), 32'd2);
    chk("d1_res_tag", 32'(res_tag), 32'd1);
    advance();
    disp(5'd3); step();

    // Out-of-order completion, in-order retirement.
    idle(); wb_valid = 1'b1; wb_tag = 4'd1; wb_value = 32'h100; step();
    wb_tag = 4'd2; wb_value = 32'h200;
    settle(); chk("ooo_nocommit", 32'(com_en), 32'd0); advance();
    wb_tag = 4'd0; wb_value = 32'hDEAD;
    settle(); chk("wb_same_cycle", 32'(com_en), 32'd0); advance();
    wb_valid = 1'b0;
    settle();
    chk("c0_en", 32'(com_en), 32'd1);
    chk("c0_des", 32'(com_des), 32'd1);
    chk("c0_val", com_val, 32'hDEAD);
    chk("c0_tag", 32'(com_tag), 32'd0);
    advance();
    settle(); chk("c1_tag", 32'(com_tag), 32'd1); chk("c1_val", com_val, 32'h100); advance();
    settle(); chk("c2_tag", 32'(com_tag), 32'd2); chk("c2_des", 32'(com_des), 32'd3); advance();
    settle(); chk("drained", 32'(rob_empty), 32'd1); advance();

    // CDB bypass, x0, stale tag readback, pending operand.
    disp(5'd4); step();
    disp(5'd6); dispatch_rs1 = 5'd4; rs1_ifr = 1'b1; rs1_rn = 4'd3;
    dispatch_rs2 = 5'd0; rs2_ifr = 1'b1; rs2_rn = 4'd5;
    wb_valid = 1'b1; wb_tag = 4'd3; wb_value = 32'd7;
    settle();
    chk("byp_ready", 32'(op1_ready), 32'd1);
    chk("byp_value", op1_value, 32'd7);
    chk("x0_ready", 32'(op2_ready), 32'd1);
    chk("x0_value", op2_value, 32'd0);
    advance();
    idle(); dispatch_rs1 = 5'd6; rs1_ifr = 1'b1; rs1_rn = 4'd4;
    dispatch_rs2 = 5'd7; rs2_ifr = 1'b1; rs2_rn = 4'd0;
    settle();
    chk("pend_ready", 32'(op1_ready), 32'd0);
    chk("pend_tag", 32'(op1_tag), 32'd4);
    chk("stale_value", op2_value, 32'hDEAD);
    advance();
    idle(); wb_valid = 1'b1; wb_tag = 4'd4; wb_value = 32'h44; step();
    idle();
    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    chk("drain_bound", 32'(q.size()), 32'd0);

    // Fill to 16, tail wraps, retire one, then reuse tag 0.
    do_reset();
    for (int i = 0; i < 16; i++) begin disp(5'(i + 1)); step(); end
    disp(5'd9); wb_valid = 1'b1; wb_tag = 4'd0; wb_value = 32'h5A;
    settle();
    chk("full_flag", 32'(rob_full), 32'd1);
    chk("full_dready", 32'(dispatch_ready), 32'd0);
    chk("full_wrap", 32'(dispatch_tag), 32'd0);
    advance();
    wb_valid = 1'b0;
    settle();
    chk("full_retire", 32'(com_en), 32'd1);
    chk("full_retire_dready", 32'(dispatch_ready), 32'd0);
    advance();
    settle();
    chk("reuse_dready", 32'(dispatch_ready), 32'd1);
    chk("reuse_tag", 32'(res_tag), 32'd0);
    advance();

    // Flush with five valid entries and a retirable head.
    do_reset();
    for (int i = 0; i < 5; i++) begin disp(5'(i + 10)); step(); end
    idle(); wb_valid = 1'b1; wb_tag = 4'd0; wb_value = 32'h77; step();
    idle(); flush_in = 1'b1; disp(5'd1);
    settle();
    chk("flush_nocommit", 32'(com_en), 32'd0);
    chk("flush_dready", 32'(dispatch_ready), 32'd0);
    chk("flush_not_empty_yet", 32'(rob_empty), 32'd0);
    advance();
    idle();
    settle(); chk("flush_empty", 32'(rob_empty), 32'd1); chk("flush_tail", 32'(dispatch_tag), 32'd0);
    advance();

    // Asynchronous reset mid-cycle.
    for (int i = 0; i < 3; i++) begin disp(5'(i + 20)); step(); end
    idle(); wb_valid = 1'b1; wb_tag = 4'd0; wb_value = 32'h99; step();
    idle();
    settle();
    #2 rst_in = 1'b0;
    model_reset();
    #1;
    chk("arst_empty", 32'(rob_empty), 32'd1);
    chk("arst_commit", 32'(com_en), 32'd0);
    chk("arst_full", 32'(rob_full), 32'd0);
    advance();
    rst_in = 1'b1;

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      rdy_in          = ($urandom_range(0, 9) != 0);
      flush_in        = rdy_in && ($urandom_range(0, 79) == 0);
      dispatch_valid  = ($urandom_range(0, 3) != 0);
      dispatch_has_rd = ($urandom_range(0, 3) != 0);
      dispatch_rd     = 5'($urandom_range(0, 31));
      dispatch_rs1    = 5'($urandom_range(0, 31));
      dispatch_rs2    = 5'($urandom_range(0, 31));
      rs1_val = $urandom; rs2_val = $urandom;
      rs1_ifr = 1'($urandom_range(0, 1)); rs2_ifr = 1'($urandom_range(0, 1));
      rs1_rn  = pick_tag(); rs2_rn = pick_tag();
      wb_valid = 1'b0; wb_tag = 4'd0; wb_value = $urandom;
      if (!flush_in && $urandom_range(0, 3) < (((c / 300) % 2 == 1) ? 1 : 3)) begin
        cand.delete();
        foreach (q[i]) if (!done[q[i].tag]) cand.push_back(q[i].tag);
        if (cand.size() > 0) begin
          wb_valid = 1'b1;
          wb_tag   = cand[$urandom_range(0, cand.size() - 1)];
        end
      end else if (!flush_in && $urandom_range(0, 19) == 0) begin
        wb_tag = 4'($urandom);
        wb_valid = !in_q(wb_tag);
      end
      if (wb_valid && $urandom_range(0, 3) == 0) begin
        rs1_ifr = 1'b1; rs1_rn = wb_tag;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
